// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Default operand width of the divider
  localparam int DIV_DATA_WIDTH = 20;

  // Counter width able to hold 0..w (one quotient bit per step)
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_DATA_WIDTH);

  // Quotient reported for a divide-by-zero request
  localparam logic [DIV_DATA_WIDTH-1:0] ALL_ONES = {DIV_DATA_WIDTH{1'b1}};

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : Combinational two's-complement subtractor,
//               diff = a + ~b + carry_in. carry_out=1 means no borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  carry_out
);

  // Widen by one bit so the carry out of the top position is captured
  always_comb begin
    {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, carry_in};
  end

endmodule : subtractor
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Sequential unsigned restoring divider. One quotient bit per
//               clock; start/ready/done handshake; divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  // Package constants are exact for the default width; other widths derive their own
  localparam int C_CNT_W = (DATA_WIDTH == DIV_DATA_WIDTH) ? CNT_W : cnt_width(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] C_ALL_ONES =
    (DATA_WIDTH == DIV_DATA_WIDTH) ? DATA_WIDTH'(ALL_ONES) : {DATA_WIDTH{1'b1}};
  localparam logic [C_CNT_W-1:0] C_LAST_STEP = C_CNT_W'(DATA_WIDTH - 1);

  div_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;              // dividend being shifted into quotient
  logic [DATA_WIDTH-1:0] r_q, r_d;              // partial remainder
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;  // captured divisor
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;          // step counter
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  // Trial value and subtraction result for the current step
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   sub_diff;
  logic                  sub_carry;
  logic                  sub_diff_msb_unused;

  assign trial               = {r_q, q_q[DATA_WIDTH-1]};
  // When no borrow occurs the top bit of the difference is always zero
  assign sub_diff_msb_unused = sub_diff[DATA_WIDTH];

  subtractor #(
    .DATA_WIDTH (DATA_WIDTH + 1)
  ) u_subtractor (
    .a         (trial),
    .b         ({1'b0, divisor_q}),
    .carry_in  (1'b1),
    .diff      (sub_diff),
    .carry_out (sub_carry)
  );

  // Next-state, datapath update and result capture
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_d       = dividend;
            r_d       = '0;
            divisor_d = divisor;
            cnt_d     = '0;
            state_d   = RUN;
          end else begin
            // Division by zero bypasses the iteration entirely
            quotient_d  = C_ALL_ONES;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end

      RUN: begin
        if (sub_carry) begin
          r_d = sub_diff[DATA_WIDTH-1:0];
          q_d = {q_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial[DATA_WIDTH-1:0];
          q_d = {q_q[DATA_WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_STEP) begin
          quotient_d  = q_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      r_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule : restoring_divider
`default_nettype wire
